// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencing controller.
//   state_t   : controller FSM states
//   alu_op_t  : ALU operation codes
//   key_ev_t  : one bit per keypad strobe (operator keys and Start)
//   DISP_ERR  : display sentinel shown while in the error state
package calc_pkg;

    typedef enum logic [2:0] {
        S_ENTA,
        S_ENTB,
        S_EXEC,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } alu_op_t;

    typedef struct packed {
        logic start;
        logic add;
        logic sub;
        logic mul;
        logic div;
    } key_ev_t;

    localparam logic [15:0] DISP_ERR = 16'h8000;

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// Start/done handshake between the sequencing controller and the ALU.
//   master (controller): drives alu_start, alu_op, alu_a, alu_b
//                        samples alu_done, alu_result, alu_ovf
//   slave  (ALU)       : the mirror image
interface calc_seq_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic                 alu_start;
    calc_pkg::alu_op_t    alu_op;
    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic                 alu_done;
    logic [WIDTH-1:0]     alu_result;
    logic                 alu_ovf;

    modport master (
        output alu_start, alu_op, alu_a, alu_b,
        input  alu_done, alu_result, alu_ovf
    );

    modport slave (
        input  alu_start, alu_op, alu_a, alu_b,
        output alu_done, alu_result, alu_ovf
    );
endinterface

// File: rtl/key_edge_prio.sv
// Rising-edge detector and priority picker for the keypad strobes.
//   clk, rst : clock, synchronous active-high reset
//   keys     : raw key levels
//   ev       : registered one-hot event (Start > Add > Sub > Mult > Div)
//   op       : registered ALU code matching the chosen operator event
module key_edge_prio
    import calc_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  key_ev_t keys,
    output key_ev_t ev,
    output alu_op_t op
);

    logic [4:0] prev;
    key_ev_t    rise_c;
    key_ev_t    sel_c;
    alu_op_t    code_c;

    assign rise_c = key_ev_t'(keys & ~prev);

    // Keep only the highest-priority edge of this cycle
    always_comb begin
        sel_c  = '0;
        code_c = OP_ADD;
        if (rise_c.start) begin
            sel_c.start = 1'b1;
        end else if (rise_c.add) begin
            sel_c.add = 1'b1;
            code_c    = OP_ADD;
        end else if (rise_c.sub) begin
            sel_c.sub = 1'b1;
            code_c    = OP_SUB;
        end else if (rise_c.mul) begin
            sel_c.mul = 1'b1;
            code_c    = OP_MUL;
        end else if (rise_c.div) begin
            sel_c.div = 1'b1;
            code_c    = OP_DIV;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
            ev   <= '0;
            op   <= OP_ADD;
        end else begin
            prev <= keys;
            ev   <= sel_c;
            op   <= code_c;
        end
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Sequencing controller between the keypad input unit and the ALU.
// Latches operands A/B, launches one ALU operation per Start, handles
// divide-by-zero, overflow and ALU timeout, and picks the display value.
//   Clock, Clear           : clock, synchronous active-high reset
//   Add/Sub/Mult/Div/Start : key levels from the input unit
//   Operand                : current signed operand from the input unit
//   alu                    : ALU start/done handshake (master side)
//   disp_value             : value routed to the display decoders
//   busy, err              : operation in flight / error state
// Build option: define CALC_CHAIN_EN to let an operator key in S_DONE
// chain the previous result in as operand A.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    Clock,
    input  logic                    Clear,
    input  logic                    Add,
    input  logic                    Sub,
    input  logic                    Mult,
    input  logic                    Div,
    input  logic                    Start,
    input  logic signed [WIDTH-1:0] Operand,
    calc_seq_ctrl_if.master         alu,
    output logic [WIDTH-1:0]        disp_value,
    output logic                    busy,
    output logic                    err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t           state;
    key_ev_t          ev;
    alu_op_t          ev_op;
    logic             op_ev;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] result_q;

    key_edge_prio u_keys (
        .clk  (Clock),
        .rst  (Clear),
        .keys (key_ev_t'({Start, Add, Sub, Mult, Div})),
        .ev   (ev),
        .op   (ev_op)
    );

    assign op_ev = ev.add | ev.sub | ev.mul | ev.div;

    // Controller FSM; busy/err/alu_start are set from the state being entered
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state         <= S_ENTA;
            alu.alu_start <= 1'b0;
            alu.alu_op    <= OP_ADD;
            alu.alu_a     <= '0;
            alu.alu_b     <= '0;
            busy          <= 1'b0;
            err           <= 1'b0;
            cnt           <= '0;
            result_q      <= '0;
        end else begin
            alu.alu_start <= 1'b0;
            case (state)
                S_ENTA: begin
                    if (op_ev) begin
                        alu.alu_a  <= Operand;
                        alu.alu_op <= ev_op;
                        state      <= S_ENTB;
                    end
                end
                S_ENTB: begin
                    if (op_ev) begin
                        alu.alu_op <= ev_op;
                    end else if (ev.start) begin
                        alu.alu_b <= Operand;
                        if (alu.alu_op == OP_DIV && Operand == '0) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end else begin
                            state         <= S_EXEC;
                            alu.alu_start <= 1'b1;
                            busy          <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // done beats a timeout landing on the same cycle
                    if (alu.alu_done) begin
                        result_q <= alu.alu_result;
                        busy     <= 1'b0;
                        if (alu.alu_ovf) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end else begin
                            state <= S_DONE;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (ev.start) begin
                        state <= S_ENTA;
`ifdef CALC_CHAIN_EN
                    end else if (op_ev) begin
                        alu.alu_a  <= result_q;
                        alu.alu_op <= ev_op;
                        state      <= S_ENTB;
`endif
                    end
                end
                S_ERR: begin
                    if (ev.start) begin
                        state <= S_ENTA;
                        err   <= 1'b0;
                    end
                end
                default: begin
                    state <= S_ENTA;
                end
            endcase
        end
    end

    // Display source follows the current state
    always_comb begin
        disp_value = Operand;
        case (state)
            S_EXEC, S_WAIT: disp_value = alu.alu_a;
            S_DONE:         disp_value = result_q;
            S_ERR:          disp_value = WIDTH'(DISP_ERR);
            default:        disp_value = Operand;
        endcase
    end

endmodule
